// File: rtl/sound_pkg.sv
// Shared sound-path definitions: tone mode encoding and clocking constants.
package sound_pkg;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} mode_t;

  localparam int CLK_HZ = 10_000_000;
  localparam int STEPS  = 256;
endpackage

// File: rtl/tone_oscillator.sv
// Square-wave tone generator: divides clk so at_max toggles every
// CLK_HZ/(STEPS*freq) cycles while playSound is high.
module tone_oscillator
  import sound_pkg::*;
#(
  parameter int CLK_HZ_P = sound_pkg::CLK_HZ,
  parameter int STEPS_P  = sound_pkg::STEPS,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [8:0] freq,
  input  logic       playSound,
  output logic       at_max,
  output logic       state
);

  // Single-cycle combinational limit; freq==0 maps to 0 to avoid dividing by zero.
  function automatic logic [CNT_W-1:0] tone_limit(input logic [8:0] f);
    logic [31:0] prod;
    logic [31:0] quot;
    prod = 32'(STEPS_P) * {23'd0, f};
    quot = (f == 9'd0) ? 32'd0 : 32'(CLK_HZ_P) / prod;
    return CNT_W'(quot);
  endfunction

  logic [CNT_W-1:0] w_lim;
  logic [CNT_W-1:0] w_lim_m1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_at_max;
  mode_t            r_state;

  assign w_lim    = tone_limit(freq);
  assign w_lim_m1 = w_lim - CNT_W'(1);

  // Counter follows playSound directly, so the first toggle lands N edges after it is sampled.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt    <= '0;
      r_at_max <= 1'b0;
      r_state  <= OFF;
    end else begin
      r_state <= playSound ? ON : OFF;
      if (!playSound || w_lim == '0) begin
        r_cnt    <= '0;
        r_at_max <= 1'b0;
      end else if (r_cnt >= w_lim_m1) begin
        r_cnt    <= '0;
        r_at_max <= ~r_at_max;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign at_max = r_at_max;
  assign state  = r_state;

endmodule

// File: tb/tb_tone_oscillator.sv
// Directed bench for tone_oscillator with hand-computed toggle points.
module tb_tone_oscillator;
  logic       clk;
  logic       nRst;
  logic [8:0] freq;
  logic       playSound;
  logic       at_max;
  logic       state;

  int checks   = 0;
  int failures = 0;

  tone_oscillator dut (
    .clk       (clk),
    .nRst      (nRst),
    .freq      (freq),
    .playSound (playSound),
    .at_max    (at_max),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    nRst = 1'b1; freq = 9'd0; playSound = 1'b0;

    // 1: async reset mid-cycle, held across edges, released off-edge
    #2 nRst = 1'b0;
    #1;
    chk("rst_at_max", at_max, 1'b0);
    chk("rst_state", state, 1'b0);
    freq = 9'd440; playSound = 1'b1;
    step(3);
    chk("rst_hold_at_max", at_max, 1'b0);
    chk("rst_hold_state", state, 1'b0);
    playSound = 1'b0;
    @(negedge clk) nRst = 1'b1;
    step(2);
    chk("post_rst_at_max", at_max, 1'b0);
    chk("post_rst_state", state, 1'b0);

    // 2: freq=440 -> N=88
    freq = 9'd440; playSound = 1'b1;
    step(84);
    chk("f440_84", at_max, 1'b0);
    chk("f440_state_on", state, 1'b1);
    step(5);
    chk("f440_89", at_max, 1'b1);
    step(86);
    chk("f440_175", at_max, 1'b1);
    step(1);
    chk("f440_176", at_max, 1'b0);

    // 3: freq=311 -> N=125
    playSound = 1'b0; step(1);
    chk("restart1_at_max", at_max, 1'b0);
    freq = 9'd311; playSound = 1'b1;
    step(120);
    chk("f311_120", at_max, 1'b0);
    step(6);
    chk("f311_126", at_max, 1'b1);

    // 4: freq=262 -> N=149
    playSound = 1'b0; step(1);
    freq = 9'd262; playSound = 1'b1;
    step(145);
    chk("f262_145", at_max, 1'b0);
    step(5);
    chk("f262_150", at_max, 1'b1);

    // 5: drop playSound while high, then freq=0 silence
    playSound = 1'b0;
    step(1);
    chk("drop_at_max", at_max, 1'b0);
    chk("drop_state", state, 1'b0);
    freq = 9'd0; playSound = 1'b1;
    step(300);
    chk("f0_at_max", at_max, 1'b0);
    chk("f0_state", state, 1'b1);

    // freq lowered limit below current count: wrap on the very next edge
    freq = 9'd262;
    step(140);
    chk("shrink_pre", at_max, 1'b0);
    freq = 9'd440;
    step(1);
    chk("shrink_wrap", at_max, 1'b1);

    // 6: reset mid-tone, then restart counts from zero
    playSound = 1'b0; step(1);
    playSound = 1'b1;
    step(100);
    chk("mid_pre_rst", at_max, 1'b1);
    nRst = 1'b0;
    #2;
    chk("mid_rst_at_max", at_max, 1'b0);
    chk("mid_rst_state", state, 1'b0);
    @(negedge clk) nRst = 1'b1;
    step(1);
    chk("mid_rel_state", state, 1'b1);
    step(86);
    chk("mid_rel_87", at_max, 1'b0);
    step(1);
    chk("mid_rel_88", at_max, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
